// File: rtl/run_control_fsm.sv
// Run/halt/single-step sequencer driving the CPU PC write enable, with retired-instruction and halt counters.
// Optional PC breakpoint logic is compiled in when RUN_CTRL_BREAKPOINT_EN is defined.
//
//   state | meaning
//   ------+-----------------------------------------------
//   RUN   | PC advances every cycle until a halt event
//   HALT  | PC frozen, waiting for a go edge
//   STEP  | one instruction executes, then back to HALT
//   11    | unreachable encoding, recovers to HALT
module run_control_fsm #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall,
  input  logic             show,
  input  logic             go,
  input  logic             step_mode,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             pc_enable,
  output logic             halted,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] halt_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALT    = 2'b01,
    ST_STEP    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;
  logic   go_q;
  logic   go_rise;
  logic   halt_req;
  logic   bp_stop;
  logic   halt_inc;
  logic   bp_set;
  logic   bp_clr;

  assign go_rise  = go & ~go_q;
  assign halt_req = syscall & ~show;

  always_comb begin
    state_d  = state_q;
    halt_inc = 1'b0;
    bp_set   = 1'b0;
    bp_clr   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Breakpoint outranks a coincident halting syscall.
        if (bp_stop) begin
          state_d  = ST_HALT;
          halt_inc = 1'b1;
          bp_set   = 1'b1;
        end else if (halt_req) begin
          state_d  = ST_HALT;
          halt_inc = 1'b1;
          bp_clr   = 1'b1;
        end
      end
      ST_HALT: begin
        if (go_rise) state_d = step_mode ? ST_STEP : ST_RUN;
      end
      ST_STEP:    state_d = ST_HALT;
      ST_ILLEGAL: state_d = ST_HALT;
      default:    state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      go_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      go_q    <= go;
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_skip;
  logic bp_hit_q;

  assign bp_stop = (state_q == ST_RUN) & bp_valid & (pc == bp_addr) & ~bp_skip;
  assign bp_hit  = bp_hit_q;

  // bp_skip lets the resumed instruction at bp_addr execute once without re-trapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      if (state_q == ST_HALT && state_d != ST_HALT) bp_skip <= 1'b1;
      else if (state_q == ST_RUN || state_q == ST_STEP) bp_skip <= 1'b0;
      if (bp_set) bp_hit_q <= 1'b1;
      else if (bp_clr) bp_hit_q <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_valid, bp_addr, bp_set, bp_clr};
`endif

  assign pc_enable = (state_q == ST_RUN && !bp_stop) || (state_q == ST_STEP);
  assign halted    = (state_q == ST_HALT);
  assign state     = state_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      halt_count  <= '0;
    end else begin
      if (pc_enable && !(&cycle_count)) cycle_count <= cycle_count + CNT_ONE;
      if (halt_inc && !(&halt_count))   halt_count  <= halt_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_run_control_fsm.sv
// Directed-vector bench for run_control_fsm, built with 4-bit counters so saturation is reachable.
// Breakpoint checks follow RUN_CTRL_BREAKPOINT_EN in the same way as the design.
module tb_run_control_fsm;

  localparam int CNT_W = 4;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             syscall;
  logic             show;
  logic             go;
  logic             step_mode;
  logic [PC_W-1:0]  pc;
  logic             bp_valid;
  logic [PC_W-1:0]  bp_addr;
  logic             pc_enable;
  logic             halted;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] halt_count;

  int n_cmp = 0;
  int n_bad = 0;

  run_control_fsm #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .syscall     (syscall),
    .show        (show),
    .go          (go),
    .step_mode   (step_mode),
    .pc          (pc),
    .bp_valid    (bp_valid),
    .bp_addr     (bp_addr),
    .pc_enable   (pc_enable),
    .halted      (halted),
    .state       (state),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .halt_count  (halt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    syscall   = 1'b0;
    show      = 1'b0;
    go        = 1'b1;
    step_mode = 1'b0;
    pc        = 32'h0040_0000;
    bp_valid  = 1'b0;
    bp_addr   = 32'h0040_0010;

    // T1: reset held with go high, then released with go still high
    tick();
    tick();
    check_val("t1_state", 32'(state), 32'd0);
    check_val("t1_pc_en", 32'(pc_enable), 32'd1);
    check_val("t1_halted", 32'(halted), 32'd0);
    check_val("t1_cycles", 32'(cycle_count), 32'd0);
    check_val("t1_halts", 32'(halt_count), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check_val("t1_post_state", 32'(state), 32'd0);
    check_val("t1_post_cycles", 32'(cycle_count), 32'd2);

    // T2: halting syscall in the fifth RUN cycle
    go = 1'b0;
    do_reset();
    repeat (4) tick();
    syscall = 1'b1;
    check_val("t2_sys_pc_en", 32'(pc_enable), 32'd1);
    tick();
    syscall = 1'b0;
    check_val("t2_halted", 32'(halted), 32'd1);
    check_val("t2_pc_en", 32'(pc_enable), 32'd0);
    check_val("t2_halts", 32'(halt_count), 32'd1);
    check_val("t2_cycles", 32'(cycle_count), 32'd5);
    syscall = 1'b1;
    tick();
    tick();
    syscall = 1'b0;
    check_val("t2_halt_sys_state", 32'(state), 32'd1);
    check_val("t2_halt_sys_halts", 32'(halt_count), 32'd1);
    check_val("t2_halt_sys_cycles", 32'(cycle_count), 32'd5);

    // T3: display-only syscall keeps running
    do_reset();
    syscall = 1'b1;
    show    = 1'b1;
    repeat (3) tick();
    check_val("t3_state", 32'(state), 32'd0);
    check_val("t3_pc_en", 32'(pc_enable), 32'd1);
    check_val("t3_halts", 32'(halt_count), 32'd0);
    check_val("t3_cycles", 32'(cycle_count), 32'd3);
    syscall = 1'b0;
    show    = 1'b0;

    // T4: single step, held go, syscall during STEP, resume to RUN
    do_reset();
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    step_mode = 1'b1;
    go = 1'b1;
    tick();
    check_val("t4_step_state", 32'(state), 32'd2);
    check_val("t4_step_pc_en", 32'(pc_enable), 32'd1);
    tick();
    check_val("t4_back_state", 32'(state), 32'd1);
    check_val("t4_back_pc_en", 32'(pc_enable), 32'd0);
    check_val("t4_back_cycles", 32'(cycle_count), 32'd2);
    repeat (10) tick();
    check_val("t4_hold_state", 32'(state), 32'd1);
    check_val("t4_hold_cycles", 32'(cycle_count), 32'd2);
    check_val("t4_hold_halts", 32'(halt_count), 32'd1);
    go = 1'b0;
    tick();
    go = 1'b1;
    syscall = 1'b1;
    tick();
    check_val("t4_step2_state", 32'(state), 32'd2);
    tick();
    syscall = 1'b0;
    check_val("t4_step_sys_state", 32'(state), 32'd1);
    check_val("t4_step_sys_halts", 32'(halt_count), 32'd1);
    check_val("t4_step_sys_cycles", 32'(cycle_count), 32'd3);
    go = 1'b0;
    step_mode = 1'b0;
    tick();
    go = 1'b1;
    tick();
    check_val("t4_run_state", 32'(state), 32'd0);
    check_val("t4_run_pc_en", 32'(pc_enable), 32'd1);
    go = 1'b0;

    // T5: counter saturation at 4'hF
    do_reset();
    repeat (14) tick();
    check_val("t5_cycles_14", 32'(cycle_count), 32'd14);
    tick();
    check_val("t5_cycles_15", 32'(cycle_count), 32'd15);
    repeat (5) tick();
    check_val("t5_cycles_sat", 32'(cycle_count), 32'd15);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      syscall = 1'b1;
      tick();
      syscall = 1'b0;
      go = 1'b1;
      tick();
      go = 1'b0;
      if (i == 13) check_val("t5_halts_14", 32'(halt_count), 32'd14);
    end
    check_val("t5_halts_sat", 32'(halt_count), 32'd15);

`ifdef RUN_CTRL_BREAKPOINT_EN
    // T6: breakpoint stop, resume without re-trigger, syscall clears, priority
    do_reset();
    bp_valid = 1'b1;
    pc = 32'h0040_000C;
    check_val("t6_pre_pc_en", 32'(pc_enable), 32'd1);
    tick();
    pc = 32'h0040_0010;
    check_val("t6_bp_pc_en", 32'(pc_enable), 32'd0);
    tick();
    check_val("t6_bp_state", 32'(state), 32'd1);
    check_val("t6_bp_hit", 32'(bp_hit), 32'd1);
    check_val("t6_bp_halts", 32'(halt_count), 32'd1);
    go = 1'b1;
    tick();
    check_val("t6_resume_state", 32'(state), 32'd0);
    check_val("t6_resume_pc_en", 32'(pc_enable), 32'd1);
    tick();
    pc = 32'h0040_0014;
    check_val("t6_after_state", 32'(state), 32'd0);
    check_val("t6_after_halts", 32'(halt_count), 32'd1);
    check_val("t6_sticky_hit", 32'(bp_hit), 32'd1);
    go = 1'b0;
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    check_val("t6_sys_clr_hit", 32'(bp_hit), 32'd0);
    check_val("t6_sys_halts", 32'(halt_count), 32'd2);
    go = 1'b1;
    tick();
    tick();
    pc = 32'h0040_0010;
    syscall = 1'b1;
    check_val("t6_prio_pc_en", 32'(pc_enable), 32'd0);
    tick();
    syscall = 1'b0;
    check_val("t6_prio_hit", 32'(bp_hit), 32'd1);
    check_val("t6_prio_halts", 32'(halt_count), 32'd3);
    check_val("t6_prio_state", 32'(state), 32'd1);
    go = 1'b0;
    bp_valid = 1'b0;
`else
    // Breakpoint logic absent: matching PC must not stop the CPU
    do_reset();
    bp_valid = 1'b1;
    pc = 32'h0040_0010;
    check_val("t6_off_pc_en", 32'(pc_enable), 32'd1);
    tick();
    check_val("t6_off_state", 32'(state), 32'd0);
    check_val("t6_off_hit", 32'(bp_hit), 32'd0);
    bp_valid = 1'b0;
`endif

    // Reset wins over a simultaneous halting syscall
    do_reset();
    repeat (3) tick();
    syscall = 1'b1;
    rst = 1'b1;
    tick();
    check_val("rst_prio_state", 32'(state), 32'd0);
    check_val("rst_prio_halts", 32'(halt_count), 32'd0);
    check_val("rst_prio_cycles", 32'(cycle_count), 32'd0);
    rst = 1'b0;
    syscall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
